// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Brief    : Shared constants and types for the 3-stage MIPS-subset core.
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  // WB result source select; encoding 3 is reserved and falls back to ALU
  localparam logic [1:0] REGSEL_ALU = 2'd0;
  localparam logic [1:0] REGSEL_HI  = 2'd1;
  localparam logic [1:0] REGSEL_LO  = 2'd2;

  // Decoded control carried from EX into WB
  typedef struct packed {
    logic       regwrite;
    logic [1:0] regsel;
    logic       enhilo;
    logic       rdrt;
    logic       gpio_out;
    logic       gpio_in;
  } exwb_ctrl_t;

  // Squash every enable of a killed or bubble instruction; selects pass through
  function automatic exwb_ctrl_t gate_ctrl(input exwb_ctrl_t c, input logic live);
    exwb_ctrl_t g;
    g          = c;
    g.regwrite = c.regwrite & live;
    g.enhilo   = c.enhilo   & live;
    g.gpio_out = c.gpio_out & live;
    g.gpio_in  = c.gpio_in  & live;
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Brief    : Parameterised-width two-flop synchroniser, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/ex_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_wb_stage
// Brief    : EX->WB pipeline register and writeback stage. Owns HI/LO, the
//            GPIO output register, the GPIO input synchroniser and instret.
// Revision : 1.0 - initial release
// ============================================================================
module ex_wb_stage
  import core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_EX,
  input  logic              flush_EX,
  input  logic              regwrite_EX,
  input  logic [1:0]        regsel_EX,
  input  logic              enhilo_EX,
  input  logic              rdrt_EX,
  input  logic              GPIO_OUT_EX,
  input  logic              GPIO_IN_EX,
  input  logic [REG_AW-1:0] rt_EX,
  input  logic [REG_AW-1:0] rd_EX,
  input  logic [DATA_W-1:0] rtdata_EX,
  input  logic [DATA_W-1:0] alu_lo_EX,
  input  logic [DATA_W-1:0] alu_hi_EX,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              regwrite_WB,
  output logic [REG_AW-1:0] writeaddr_WB,
  output logic [DATA_W-1:0] writedata_WB,
  output logic [31:0]       instret
);

  logic              live;
  exwb_ctrl_t        ctrl_d;
  exwb_ctrl_t        ctrl_q;
  logic [REG_AW-1:0] waddr_d;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] res_d;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] gpio_out_q;
  logic [31:0]       instret_q;
  logic [DATA_W-1:0] gpio_sync;
  logic [DATA_W-1:0] wdata;

  assign live = valid_EX & ~flush_EX;

  // Assemble the next pipeline-register contents with enables gated by live
  always_comb begin
    ctrl_d          = '0;
    ctrl_d.regwrite = regwrite_EX;
    ctrl_d.regsel   = regsel_EX;
    ctrl_d.enhilo   = enhilo_EX;
    ctrl_d.rdrt     = rdrt_EX;
    ctrl_d.gpio_out = GPIO_OUT_EX;
    ctrl_d.gpio_in  = GPIO_IN_EX;
    ctrl_d          = gate_ctrl(ctrl_d, live);
    waddr_d         = rdrt_EX ? rt_EX : rd_EX;
    // A GPIO-out instruction writes the rt value into rd as well
    res_d           = GPIO_OUT_EX ? rtdata_EX : alu_lo_EX;
  end

  // EX->WB pipeline register, captured every cycle including bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      waddr_q <= '0;
      res_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      waddr_q <= waddr_d;
      res_q   <= res_d;
    end
  end

  // HI/LO update at the end of EX so a following mfhi/mflo needs no bypass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (ctrl_d.enhilo) begin
      hi_q <= alu_hi_EX;
      lo_q <= alu_lo_EX;
    end
  end

  // GPIO output register, loaded only by a live GPIO-out instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out_q <= '0;
    end else if (ctrl_d.gpio_out) begin
      gpio_out_q <= rtdata_EX;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (live) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  sync2 #(
    .WIDTH (DATA_W)
  ) u_gpio_sync (
    .clk   (clk),
    .rst_n (rst),
    .d_i   (gpio_in),
    .q_o   (gpio_sync)
  );

  // WB data select; GPIO read wins because the decoder also raises regsel=HI
  always_comb begin
    wdata = res_q;
    if (ctrl_q.gpio_in) begin
      wdata = gpio_sync;
    end else if (ctrl_q.regsel == REGSEL_HI) begin
      wdata = hi_q;
    end else if (ctrl_q.regsel == REGSEL_LO) begin
      wdata = lo_q;
    end
  end

  // Fields consumed in EX only; kept in the bundle for visibility in WB
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, ctrl_q.enhilo, ctrl_q.rdrt, ctrl_q.gpio_out};

  assign regwrite_WB  = ctrl_q.regwrite & (waddr_q != '0);
  assign writeaddr_WB = waddr_q;
  assign writedata_WB = wdata;
  assign gpio_out     = gpio_out_q;
  assign instret      = instret_q;

endmodule
`default_nettype wire
